// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_IDX_W-1:0] idx);
    logic [ARB_N-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping 7->0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic                 any,
  output logic [ARB_IDX_W-1:0] idx
);

  logic [ARB_N-1:0]     rot;
  logic [ARB_IDX_W-1:0] k;

  // Rotate so that bit 0 of rot corresponds to requester ptr+1.
  always_comb begin
    for (int i = 0; i < ARB_N; i++) begin
      rot[i] = req[ARB_IDX_W'(i) + ptr + ARB_IDX_W'(1)];
    end
  end

  always_comb begin
    k = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) k = ARB_IDX_W'(i);
    end
  end

  assign any = |req;
  assign idx = k + ptr + ARB_IDX_W'(1);

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux, with grant watchdog.
// Optional build macro ARB_PRIO0_EN gives requester 0 absolute priority.
module mux8_rr_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  input  logic                 out_ready,
  output logic [ARB_IDX_W-1:0] sel,
  output logic [ARB_N-1:0]     gnt,
  output logic                 out_valid,
  output logic [ARB_N-1:0]     done,
  output logic                 err
);

  arb_state_e           state_q, state_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [ARB_IDX_W-1:0] sel_d;
  logic [ARB_N-1:0]     gnt_d, done_d;
  logic                 ov_d, err_d;

  logic                 busy;
  logic [ARB_N-1:0]     elig;
  logic [ARB_N-1:0]     pick_req;
  logic [ARB_IDX_W-1:0] pick_base;
  logic                 pick_any;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 win_any;
  logic [ARB_IDX_W-1:0] win_idx;
  logic [ARB_IDX_W-1:0] ptr_upd;
  logic                 wd_fire;

  assign busy = (state_q == ARB_BUSY);
  // While busy the current holder is excluded so it cannot win twice in a row.
  assign elig = busy ? (req & ~gnt) : req;

`ifdef ARB_PRIO0_EN
  assign pick_req  = {elig[ARB_N-1:1], 1'b0};
  assign pick_base = (busy && sel != '0) ? sel : ptr_q;
  assign win_any   = elig[0] | pick_any;
  assign win_idx   = elig[0] ? '0 : pick_idx;
  assign ptr_upd   = (sel == '0) ? ptr_q : sel;
`else
  assign pick_req  = elig;
  assign pick_base = busy ? sel : ptr_q;
  assign win_any   = pick_any;
  assign win_idx   = pick_idx;
  assign ptr_upd   = sel;
`endif

  assign wd_fire = (TIMEOUT > 0) && (cnt_q == TO_W'(TIMEOUT - 1));

  rr_pick8 u_pick (
    .req (pick_req),
    .ptr (pick_base),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Withdrawal outranks acceptance; acceptance outranks the watchdog.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel;
    gnt_d   = gnt;
    ov_d    = out_valid;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          state_d = ARB_BUSY;
          sel_d   = win_idx;
          gnt_d   = onehot8(win_idx);
          ov_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (!req[sel]) begin
          err_d   = 1'b1;
          ptr_d   = ptr_upd;
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ov_d    = 1'b0;
        end else if (out_ready) begin
          done_d = onehot8(sel);
          ptr_d  = ptr_upd;
          if (win_any) begin
            sel_d = win_idx;
            gnt_d = onehot8(win_idx);
            cnt_d = '0;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            ov_d    = 1'b0;
          end
        end else if (wd_fire) begin
          err_d   = 1'b1;
          ptr_d   = ptr_upd;
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ov_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= ARB_IDX_W'(ARB_N - 1);
      cnt_q     <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sel       <= sel_d;
      gnt       <= gnt_d;
      out_valid <= ov_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: vector table, directed corner sequences, random vs model.
module tb_mux8_rr_arbiter;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic [7:0] done;
  logic       err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit         m_busy;
  int         m_sel;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] m_done;
  bit         m_err;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       rstn;
    logic [7:0] gnt;
    logic       ov;
    logic [7:0] done;
    logic       err;
  } vec_t;

  vec_t vecs[11];

  mux8_rr_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int search(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] bitOf(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  function automatic logic [2:0] idxOf(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic modelStep(input logic [7:0] r, input logic rdy, input logic rstn);
    int pick;
    m_done = 8'h00;
    m_err  = 1'b0;
    if (!rstn) begin
      m_busy = 1'b0; m_sel = 0; m_ptr = 7; m_cnt = 0;
    end else if (!m_busy) begin
      if (r != 8'h00) begin
        m_sel = search(r, m_ptr); m_busy = 1'b1; m_cnt = 0;
      end
    end else if (!r[m_sel]) begin
      m_err = 1'b1; m_ptr = m_sel; m_busy = 1'b0;
    end else if (rdy) begin
      m_done = bitOf(m_sel);
      m_ptr  = m_sel;
      pick   = search(r & ~bitOf(m_sel), m_sel);
      if (pick >= 0) begin
        m_sel = pick; m_cnt = 0;
      end else begin
        m_busy = 1'b0;
      end
    end else if (m_cnt == TIMEOUT - 1) begin
      m_err = 1'b1; m_ptr = m_sel; m_busy = 1'b0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic rdy, input logic rstn);
    req       = r;
    out_ready = rdy;
    rst_n     = rstn;
    modelStep(r, rdy, rstn);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eg, input logic eov,
                             input logic [7:0] ed, input logic ee, input bit chkSel,
                             input logic [2:0] es);
    tests++;
    if ({gnt, out_valid, done, err} !== {eg, eov, ed, ee}) begin
      fails++;
      $display("[TB] FAIL %s: gnt=%h ov=%b done=%h err=%b, expected gnt=%h ov=%b done=%h err=%b",
               name, gnt, out_valid, done, err, eg, eov, ed, ee);
    end
    if (chkSel) begin
      tests++;
      if (sel !== es) begin
        fails++;
        $display("[TB] FAIL %s_sel: sel=%0d, expected %0d", name, sel, es);
      end
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_busy ? bitOf(m_sel) : 8'h00, m_busy, m_done, m_err,
                m_busy, 3'(m_sel));
  endtask

  initial begin
    logic [7:0] pend;
    int         busyCycles;
    bit         sawErr;
    logic       rdy;
    logic       rstn;

    req = 8'h00; out_ready = 1'b0; rst_n = 1'b0;

    // Reset then full rotation with prompt acceptance
    vecs[0]  = '{8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{8'hFF, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0};
    vecs[3]  = '{8'hFF, 1'b1, 1'b1, 8'h02, 1'b1, 8'h01, 1'b0};
    vecs[4]  = '{8'hFF, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 1'b0};
    vecs[5]  = '{8'hFF, 1'b1, 1'b1, 8'h08, 1'b1, 8'h04, 1'b0};
    vecs[6]  = '{8'hFF, 1'b1, 1'b1, 8'h10, 1'b1, 8'h08, 1'b0};
    vecs[7]  = '{8'hFF, 1'b1, 1'b1, 8'h20, 1'b1, 8'h10, 1'b0};
    vecs[8]  = '{8'hFF, 1'b1, 1'b1, 8'h40, 1'b1, 8'h20, 1'b0};
    vecs[9]  = '{8'hFF, 1'b1, 1'b1, 8'h80, 1'b1, 8'h40, 1'b0};
    vecs[10] = '{8'hFF, 1'b1, 1'b1, 8'h01, 1'b1, 8'h80, 1'b0};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].req, vecs[i].rdy, vecs[i].rstn);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ov, vecs[i].done,
                  vecs[i].err, vecs[i].ov, idxOf(vecs[i].gnt));
    end

    // Hold while not ready, then back-to-back handoff
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkModel("hold_rst");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h24, 1'b0, 1'b1);
      checkOutput("hold", 8'h04, 1'b1, 8'h00, 1'b0, 1'b1, 3'd2);
    end
    applyStimulus(8'h24, 1'b1, 1'b1);
    checkOutput("hold_accept", 8'h20, 1'b1, 8'h04, 1'b0, 1'b1, 3'd5);
    applyStimulus(8'h20, 1'b1, 1'b1);
    checkOutput("hold_last", 8'h00, 1'b0, 8'h20, 1'b0, 1'b0, 3'd0);

    // Single requester always sees a bubble between serves
    applyStimulus(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h08, 1'b1, 1'b1);
      if (i % 2 == 0) checkOutput("single_gnt", 8'h08, 1'b1, 8'h00, 1'b0, 1'b1, 3'd3);
      else            checkOutput("single_done", 8'h00, 1'b0, 8'h08, 1'b0, 1'b0, 3'd0);
    end

    // Watchdog abort after TIMEOUT busy cycles, then re-grant
    applyStimulus(8'h00, 1'b0, 1'b0);
    busyCycles = 0;
    sawErr     = 1'b0;
    for (int i = 0; i < 40 && !sawErr; i++) begin
      applyStimulus(8'h02, 1'b0, 1'b1);
      checkModel("wd_cycle");
      if (err) sawErr = 1'b1;
      else if (out_valid) busyCycles++;
    end
    tests++;
    if (!sawErr || busyCycles != TIMEOUT) begin
      fails++;
      $display("[TB] FAIL wd_len: err_seen=%0b busy_cycles=%0d, expected err after %0d",
               sawErr, busyCycles, TIMEOUT);
    end
    applyStimulus(8'h02, 1'b0, 1'b1);
    checkOutput("wd_regrant", 8'h02, 1'b1, 8'h00, 1'b0, 1'b1, 3'd1);

    // Withdrawal while granted: error, no done even with out_ready high
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h20, 1'b0, 1'b1);
    checkOutput("wd_grant5", 8'h20, 1'b1, 8'h00, 1'b0, 1'b1, 3'd5);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("withdraw", 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("withdraw_after", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);

    // Randomized traffic against the reference model
    applyStimulus(8'h00, 1'b0, 1'b0);
    pend = 8'h00;
    for (int i = 0; i < 800; i++) begin
      pend = pend & ~m_done;
      pend = pend | (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 39) == 0) pend[$urandom_range(0, 7)] = 1'b0;
      if ((i % 200) >= 160) rdy = ($urandom_range(0, 19) == 0);
      else                  rdy = ($urandom_range(0, 9) < 6);
      rstn = ($urandom_range(0, 149) != 0);
      if (!rstn) pend = 8'h00;
      applyStimulus(pend, rdy, rstn);
      checkModel("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
